// File: rtl/common_fifo_1w2r_pkg.sv
// Shared constants and helpers for the 1-write / 2-read FIFO.
// Pointers carry one extra wrap bit above the storage address.
package common_fifo_1w2r_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 3;
   localparam int DEF_DEPTH      = 1 << DEF_ADDR_WIDTH;

   typedef logic [DEF_ADDR_WIDTH:0] fifo_ptr_t;

   function automatic int fifo_depth(input int addr_width);
      return 1 << addr_width;
   endfunction

   function automatic int ptr_width(input int addr_width);
      return addr_width + 1;
   endfunction

   function automatic int count_width(input int addr_width);
      return addr_width + 1;
   endfunction

endpackage

// File: rtl/common_fifo_1w2r_ptrctl.sv
// Write/read pointer and occupancy bookkeeping for common_fifo_1w2r.
// Accept signals arrive already qualified; flush overrides everything.
module common_fifo_1w2r_ptrctl
   import common_fifo_1w2r_pkg::*;
#(
   parameter int FIFO_ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       push_acc,
   input  logic                       pop0_acc,
   input  logic                       pop1_acc,
   output logic [FIFO_ADDR_WIDTH-1:0] waddr,
   output logic [FIFO_ADDR_WIDTH-1:0] raddr,
   output logic [FIFO_ADDR_WIDTH:0]   count
);

   localparam int PW = ptr_width(FIFO_ADDR_WIDTH);
   localparam int CW = count_width(FIFO_ADDR_WIDTH);

   typedef logic [PW-1:0] ptr_t;

   ptr_t wptr;
   ptr_t rptr;
   ptr_t rstep;

   assign rstep = PW'(pop0_acc) + PW'(pop1_acc);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         wptr  <= wptr + PW'(push_acc);
         rptr  <= rptr + rstep;
         count <= count + CW'(push_acc) - CW'(pop0_acc) - CW'(pop1_acc);
      end
   end

   assign waddr = wptr[FIFO_ADDR_WIDTH-1:0];
   assign raddr = rptr[FIFO_ADDR_WIDTH-1:0];

endmodule

// File: rtl/common_fifo_1w2r.sv
// DFF-based FIFO, one push and a dual-pop read side (head and head+1).
// Define COMMON_FIFO_1W2R_BYPASS_EN to let din fall through when nearly empty.
module common_fifo_1w2r
   import common_fifo_1w2r_pkg::*;
#(
   parameter int FIFO_DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int FIFO_ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       push,
   input  logic [FIFO_DATA_WIDTH-1:0] din,
   output logic                       full,
   input  logic                       pop0,
   input  logic                       pop1,
   output logic [FIFO_DATA_WIDTH-1:0] dout0,
   output logic                       valid0,
   output logic [FIFO_DATA_WIDTH-1:0] dout1,
   output logic                       valid1,
   output logic [FIFO_ADDR_WIDTH:0]   count
);

   localparam int DEPTH = fifo_depth(FIFO_ADDR_WIDTH);
   localparam int CW    = count_width(FIFO_ADDR_WIDTH);

   logic [FIFO_DATA_WIDTH-1:0] mem [DEPTH];

   logic [FIFO_ADDR_WIDTH-1:0] waddr;
   logic [FIFO_ADDR_WIDTH-1:0] raddr;
   logic [FIFO_ADDR_WIDTH-1:0] raddr_next;
   logic                       push_acc;
   logic                       pop0_acc;
   logic                       pop1_acc;
   logic                       stored_v0;
   logic                       stored_v1;

   assign full       = (count == CW'(DEPTH));
   assign stored_v0  = (count != '0);
   assign stored_v1  = (count >= CW'(2));
   assign raddr_next = raddr + FIFO_ADDR_WIDTH'(1);

   assign push_acc = push & ~full;
   assign pop0_acc = pop0 & valid0;
   assign pop1_acc = pop1 & pop0 & valid1;

`ifdef COMMON_FIFO_1W2R_BYPASS_EN
   // A bypassed entry is still written and counted, so popping it in the
   // same cycle simply moves both pointers and leaves count alone.
   logic byp0;
   logic byp1;

   assign byp0 = push & ~flush & (count == CW'(0));
   assign byp1 = push & ~flush & (count == CW'(1));

   always_comb begin
      valid0 = stored_v0 | byp0;
      valid1 = stored_v1 | byp1;
      dout0  = '0;
      dout1  = '0;
      if (stored_v0)
         dout0 = mem[raddr];
      else if (byp0)
         dout0 = din;
      if (stored_v1)
         dout1 = mem[raddr_next];
      else if (byp1)
         dout1 = din;
   end
`else
   always_comb begin
      valid0 = stored_v0;
      valid1 = stored_v1;
      dout0  = stored_v0 ? mem[raddr]      : '0;
      dout1  = stored_v1 ? mem[raddr_next] : '0;
   end
`endif

   // Storage is deliberately left out of reset; valid gating hides stale data.
   always_ff @(posedge clk) begin
      if (push_acc && !flush)
         mem[waddr] <= din;
   end

   common_fifo_1w2r_ptrctl #(
      .FIFO_ADDR_WIDTH (FIFO_ADDR_WIDTH)
   ) u_ptrctl (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .push_acc (push_acc),
      .pop0_acc (pop0_acc),
      .pop1_acc (pop1_acc),
      .waddr    (waddr),
      .raddr    (raddr),
      .count    (count)
   );

endmodule

// File: tb/tb_common_fifo_1w2r.sv
// Directed self-checking bench for common_fifo_1w2r at default parameters.
// Exercises the COMMON_FIFO_1W2R_BYPASS_EN behaviour when that macro is defined.
module tb_common_fifo_1w2r;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        push;
   logic [31:0] din;
   logic        full;
   logic        pop0;
   logic        pop1;
   logic [31:0] dout0;
   logic        valid0;
   logic [31:0] dout1;
   logic        valid1;
   logic [3:0]  count;

   int checks;
   int failures;

   common_fifo_1w2r dut (
      .clk    (clk),
      .reset  (reset),
      .flush  (flush),
      .push   (push),
      .din    (din),
      .full   (full),
      .pop0   (pop0),
      .pop1   (pop1),
      .dout0  (dout0),
      .valid0 (valid0),
      .dout1  (dout1),
      .valid1 (valid1),
      .count  (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs, let the edge happen, then return to idle.
   task automatic applyStimulus(input logic p, input logic [31:0] d, input logic q0,
                                input logic q1, input logic f);
      push  = p;
      din   = d;
      pop0  = q0;
      pop1  = q1;
      flush = f;
      @(posedge clk);
      #1;
      push  = 1'b0;
      din   = '0;
      pop0  = 1'b0;
      pop1  = 1'b0;
      flush = 1'b0;
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      flush    = 1'b0;
      push     = 1'b0;
      din      = '0;
      pop0     = 1'b0;
      pop1     = 1'b0;

      // Reset state, then a single push becomes visible next cycle
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_count",  count,  0);
      checkOutput("rst_full",   full,   0);
      checkOutput("rst_valid0", valid0, 0);
      checkOutput("rst_valid1", valid1, 0);
      checkOutput("rst_dout0",  dout0,  0);
      reset = 1'b1;
      #1;
      applyStimulus(1'b1, 32'hA5, 1'b0, 1'b0, 1'b0);
      checkOutput("t1_valid0", valid0, 1);
      checkOutput("t1_dout0",  dout0,  32'hA5);
      checkOutput("t1_count",  count,  1);
      checkOutput("t1_valid1", valid1, 0);
      checkOutput("t1_dout1",  dout1,  0);
      applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);
      checkOutput("t1_empty", valid0, 0);

      // Fill to full, drop an overflow push, drain with dual pops
      for (int i = 1; i <= 8; i++)
         applyStimulus(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
      checkOutput("t2_full",  full,  1);
      checkOutput("t2_count", count, 8);
      applyStimulus(1'b1, 32'h9, 1'b0, 1'b0, 1'b0);
      checkOutput("t2_drop_count", count, 8);
      checkOutput("t2_drop_head",  dout0, 1);
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("t2_d0_%0d", k), dout0, 32'(2 * k + 1));
         checkOutput($sformatf("t2_d1_%0d", k), dout1, 32'(2 * k + 2));
         applyStimulus(1'b0, 0, 1'b1, 1'b1, 1'b0);
      end
      checkOutput("t2_valid0_end", valid0, 0);
      checkOutput("t2_count_end",  count,  0);

      // Wrap-around: reset to pointer 0, fill 6, pop 5, push 5
      reset = 1'b0;
      #2;
      reset = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 6; i++)
         applyStimulus(1'b1, 32'h31 + 32'(i), 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 0, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 0, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);
      checkOutput("t3_count1", count, 1);
      for (int i = 0; i < 5; i++)
         applyStimulus(1'b1, 32'h41 + 32'(i), 1'b0, 1'b0, 1'b0);
      checkOutput("t3_count6", count, 6);
      checkOutput("t3_d0_a",   dout0, 32'h36);
      checkOutput("t3_d1_a",   dout1, 32'h41);
      applyStimulus(1'b0, 0, 1'b1, 1'b1, 1'b0);
      checkOutput("t3_d0_wrap", dout0, 32'h42);
      checkOutput("t3_d1_wrap", dout1, 32'h43);
      applyStimulus(1'b0, 0, 1'b1, 1'b1, 1'b0);
      checkOutput("t3_d0_b", dout0, 32'h44);
      checkOutput("t3_d1_b", dout1, 32'h45);
      applyStimulus(1'b0, 0, 1'b1, 1'b1, 1'b0);
      checkOutput("t3_count0", count, 0);

      // pop1 alone is ignored; push with dual pop at count 2
      applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
      checkOutput("t4_pop1_only_count", count, 2);
      checkOutput("t4_pop1_only_head",  dout0, 32'h10);
      applyStimulus(1'b1, 32'h30, 1'b1, 1'b1, 1'b0);
      checkOutput("t4_count", count,  1);
      checkOutput("t4_dout0", dout0,  32'h30);
      checkOutput("t4_valid1", valid1, 0);
      applyStimulus(1'b0, 0, 1'b1, 1'b1, 1'b0);
      checkOutput("t4_pop1_at1_count", count, 0);

      // Flush beats push and pop; asynchronous reset mid-cycle
      for (int i = 0; i < 5; i++)
         applyStimulus(1'b1, 32'h50 + 32'(i), 1'b0, 1'b0, 1'b0);
      checkOutput("t5_count5", count, 5);
      applyStimulus(1'b1, 32'hEE, 1'b1, 1'b0, 1'b1);
      checkOutput("t5_flush_count",  count,  0);
      checkOutput("t5_flush_valid0", valid0, 0);
      checkOutput("t5_flush_full",   full,   0);
      applyStimulus(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h66, 1'b0, 1'b0, 1'b0);
      checkOutput("t5_after_flush_d0", dout0, 32'h55);
      checkOutput("t5_after_flush_d1", dout1, 32'h66);
      reset = 1'b0;
      #2;
      checkOutput("t5_async_count",  count,  0);
      checkOutput("t5_async_valid0", valid0, 0);
      checkOutput("t5_async_valid1", valid1, 0);
      checkOutput("t5_async_dout0",  dout0,  0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Same-cycle visibility of a push into an empty FIFO
      push = 1'b1;
      din  = 32'h77;
      #1;
`ifdef COMMON_FIFO_1W2R_BYPASS_EN
      checkOutput("t6_byp_valid0", valid0, 1);
      checkOutput("t6_byp_dout0",  dout0,  32'h77);
      applyStimulus(1'b1, 32'h77, 1'b1, 1'b0, 1'b0);
      checkOutput("t6_byp_pop_count",  count,  0);
      checkOutput("t6_byp_pop_valid0", valid0, 0);
      applyStimulus(1'b1, 32'h88, 1'b0, 1'b0, 1'b0);
      push = 1'b1;
      din  = 32'h99;
      #1;
      checkOutput("t6_byp_valid1", valid1, 1);
      checkOutput("t6_byp_dout1",  dout1,  32'h99);
      flush = 1'b1;
      #1;
      checkOutput("t6_flush_no_byp", valid1, 0);
      applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
      checkOutput("t6_flush_count", count, 0);
`else
      checkOutput("t6_nobyp_valid0", valid0, 0);
      checkOutput("t6_nobyp_dout0",  dout0,  0);
      applyStimulus(1'b1, 32'h77, 1'b1, 1'b0, 1'b0);
      checkOutput("t6_nobyp_count", count, 1);
      checkOutput("t6_nobyp_dout0_next", dout0, 32'h77);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
